// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request, response and ALU-side signals of the shared ALU arbiter
interface alu_req_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             a_valid_i;
  logic             a_ready_o;
  logic [WIDTH-1:0] a_data1_i;
  logic [WIDTH-1:0] a_data2_i;
  logic [2:0]       a_ctrl_i;
  logic             b_valid_i;
  logic             b_ready_o;
  logic [WIDTH-1:0] b_data1_i;
  logic [WIDTH-1:0] b_data2_i;
  logic [2:0]       b_ctrl_i;
  logic             a_resp_valid_o;
  logic             b_resp_valid_o;
  logic             a_resp_ready_i;
  logic             b_resp_ready_i;
  logic [WIDTH-1:0] resp_data_o;
  logic             resp_zero_o;
  logic             resp_err_o;
  logic [WIDTH-1:0] alu_data1_o;
  logic [WIDTH-1:0] alu_data2_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_data_i;
  logic             alu_zero_i;

  modport slave (
    input  a_valid_i, a_data1_i, a_data2_i, a_ctrl_i,
    input  b_valid_i, b_data1_i, b_data2_i, b_ctrl_i,
    input  a_resp_ready_i, b_resp_ready_i, alu_data_i, alu_zero_i,
    output a_ready_o, b_ready_o, a_resp_valid_o, b_resp_valid_o,
    output resp_data_o, resp_zero_o, resp_err_o,
    output alu_data1_o, alu_data2_o, alu_ctrl_o
  );

  modport master (
    output a_valid_i, a_data1_i, a_data2_i, a_ctrl_i,
    output b_valid_i, b_data1_i, b_data2_i, b_ctrl_i,
    output a_resp_ready_i, b_resp_ready_i, alu_data_i, alu_zero_i,
    input  a_ready_o, b_ready_o, a_resp_valid_o, b_resp_valid_o,
    input  resp_data_o, resp_zero_o, resp_err_o,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin two-requester front end for a shared combinational ALU
module alu_req_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int         CW       = $clog2(MUL_CYCLES + 1);
  localparam logic [2:0] CTRL_MUL = 3'b011;
  localparam logic       OWNER_A  = 1'b0;
  localparam logic       OWNER_B  = 1'b1;

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          grant_a;
  logic          grant_b;
  logic [2:0]    sel_ctrl;
  logic          illegal;

  // Ties go to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_a  = bus.a_valid_i && (!bus.b_valid_i || last_grant == OWNER_B);
    grant_b  = bus.b_valid_i && (!bus.a_valid_i || last_grant == OWNER_A);
    sel_ctrl = grant_b ? bus.b_ctrl_i : bus.a_ctrl_i;
  end

  assign bus.a_ready_o = (state == IDLE) && grant_a;
  assign bus.b_ready_o = (state == IDLE) && grant_b;
  assign illegal       = bus.alu_ctrl_o inside {3'b100, 3'b101, 3'b111};

  // The alu_* registers double as the latched op, so the ALU inputs only move on accept.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state              <= IDLE;
      last_grant         <= OWNER_B;
      owner              <= OWNER_A;
      cnt                <= '0;
      bus.alu_data1_o    <= '0;
      bus.alu_data2_o    <= '0;
      bus.alu_ctrl_o     <= 3'b000;
      bus.resp_data_o    <= '0;
      bus.resp_zero_o    <= 1'b0;
      bus.resp_err_o     <= 1'b0;
      bus.a_resp_valid_o <= 1'b0;
      bus.b_resp_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            owner           <= grant_b;
            last_grant      <= grant_b;
            bus.alu_data1_o <= grant_b ? bus.b_data1_i : bus.a_data1_i;
            bus.alu_data2_o <= grant_b ? bus.b_data2_i : bus.a_data2_i;
            bus.alu_ctrl_o  <= sel_ctrl;
            cnt             <= (sel_ctrl == CTRL_MUL) ? CW'(MUL_CYCLES - 1) : '0;
            state           <= EXEC;
          end
        end
        EXEC: begin
          if (illegal) begin
            bus.resp_data_o    <= '0;
            bus.resp_zero_o    <= 1'b1;
            bus.resp_err_o     <= 1'b1;
            cnt                <= '0;
            bus.a_resp_valid_o <= (owner == OWNER_A);
            bus.b_resp_valid_o <= (owner == OWNER_B);
            state              <= DONE;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bus.resp_data_o    <= bus.alu_data_i;
            bus.resp_zero_o    <= bus.alu_zero_i;
            bus.resp_err_o     <= 1'b0;
            bus.a_resp_valid_o <= (owner == OWNER_A);
            bus.b_resp_valid_o <= (owner == OWNER_B);
            state              <= DONE;
          end
        end
        DONE: begin
          if (owner == OWNER_A ? bus.a_resp_ready_i : bus.b_resp_ready_i) begin
            bus.a_resp_valid_o <= 1'b0;
            bus.b_resp_valid_o <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter with a behavioural ALU and arbiter model
module tb_alu_req_arbiter;
  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 4;
  localparam int NOPS       = 512;

  typedef struct packed {
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
  } op_t;

  typedef struct packed {
    logic             owner;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
    int               due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   nchk  = 0;
  int   nerr  = 0;
  int   rr_mode = 0;

  op_t  ops_a[NOPS];
  op_t  ops_b[NOPS];
  int   a_head = 0, a_tail = 0, b_head = 0, b_tail = 0;
  exp_t exp_q[$];
  logic model_busy = 1'b0;

  alu_req_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_req_arbiter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared ALU; illegal codes return junk that must never reach a response.
  always_comb begin
    bus.alu_data_i = 32'hDEAD_BEEF;
    bus.alu_zero_i = 1'b0;
    case (bus.alu_ctrl_o)
      3'b000: bus.alu_data_i = bus.alu_data1_o & bus.alu_data2_o;
      3'b001: bus.alu_data_i = bus.alu_data1_o | bus.alu_data2_o;
      3'b010: bus.alu_data_i = bus.alu_data1_o + bus.alu_data2_o;
      3'b110: bus.alu_data_i = bus.alu_data1_o - bus.alu_data2_o;
      3'b011: bus.alu_data_i = bus.alu_data1_o * bus.alu_data2_o;
      default: bus.alu_data_i = 32'hDEAD_BEEF;
    endcase
    if (!(bus.alu_ctrl_o inside {3'b100, 3'b101, 3'b111}))
      bus.alu_zero_i = (bus.alu_data_i == '0);
  end

  function automatic exp_t model(input logic own, input op_t op, input int due);
    exp_t e;
    e.owner = own;
    e.due   = due;
    e.err   = 1'b0;
    case (op.ctrl)
      3'b000: e.data = op.d1 & op.d2;
      3'b001: e.data = op.d1 | op.d2;
      3'b010: e.data = op.d1 + op.d2;
      3'b110: e.data = op.d1 - op.d2;
      3'b011: e.data = op.d1 * op.d2;
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_a(input logic [2:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    ops_a[a_tail] = '{ctrl: c, d1: x, d2: y};
    a_tail++;
  endtask

  task automatic push_b(input logic [2:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    ops_b[b_tail] = '{ctrl: c, d1: x, d2: y};
    b_tail++;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (!(a_head == a_tail && b_head == b_tail && !model_busy) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 128'(n < max_cyc), 128'(1));
  endtask

  task automatic wait_busy(input int max_cyc);
    int n = 0;
    while (!model_busy && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", 128'(model_busy), 128'(1));
  endtask

  function automatic op_t rand_op();
    logic [2:0] codes[8];
    op_t o;
    int  k;
    codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b011, 3'b100, 3'b101, 3'b111};
    k = $urandom_range(0, 11);
    o.ctrl = (k < 8) ? codes[k] : codes[$urandom_range(0, 4)];
    o.d1 = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
    o.d2 = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
    return o;
  endfunction

  // Driver: presents queue heads; valid stays up until the op is taken.
  initial begin
    bus.a_valid_i = 1'b0; bus.a_data1_i = '0; bus.a_data2_i = '0; bus.a_ctrl_i = '0;
    bus.b_valid_i = 1'b0; bus.b_data1_i = '0; bus.b_data2_i = '0; bus.b_ctrl_i = '0;
    bus.a_resp_ready_i = 1'b1;
    bus.b_resp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.a_valid_i = (a_head < a_tail);
      if (a_head < a_tail) {bus.a_ctrl_i, bus.a_data1_i, bus.a_data2_i} = ops_a[a_head];
      bus.b_valid_i = (b_head < b_tail);
      if (b_head < b_tail) {bus.b_ctrl_i, bus.b_data1_i, bus.b_data2_i} = ops_b[b_head];
      case (rr_mode)
        1:       begin bus.a_resp_ready_i = 1'($urandom_range(0, 1)); bus.b_resp_ready_i = 1'($urandom_range(0, 1)); end
        2:       begin bus.a_resp_ready_i = 1'b0; bus.b_resp_ready_i = 1'b1; end
        default: begin bus.a_resp_ready_i = 1'b1; bus.b_resp_ready_i = 1'b1; end
      endcase
    end
  end

  // Monitor: predicts grants, issues expectations, and scores responses.
  initial begin
    logic last_g   = 1'b1;
    logic chk_rst  = 1'b0;
    logic seen     = 1'b0;
    op_t  cur_op   = '0;
    logic av, bv, ea, eb;
    op_t  op;
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_rst)
        check("reset_outputs",
              128'({bus.a_resp_valid_o, bus.b_resp_valid_o, bus.resp_data_o, bus.resp_zero_o,
                    bus.resp_err_o, bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o}),
              128'(0));
      chk_rst = !rst_n;
      if (!rst_n) begin
        model_busy = 1'b0;
        last_g     = 1'b1;
        cur_op     = '0;
        seen       = 1'b0;
        exp_q.delete();
      end else begin
        check("alu_hold", 128'({bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o}), 128'(cur_op));
        av = bus.a_valid_i;
        bv = bus.b_valid_i;
        ea = !model_busy && av && (!bv || last_g);
        eb = !model_busy && bv && (!av || !last_g);
        if (av || bv || bus.a_ready_o || bus.b_ready_o)
          check("grant", 128'({bus.a_ready_o, bus.b_ready_o}), 128'({ea, eb}));
        if (ea || eb) begin
          op = ea ? ops_a[a_head] : ops_b[b_head];
          exp_q.push_back(model(eb, op, cyc + ((op.ctrl == 3'b011) ? 1 + MUL_CYCLES : 2)));
          if (ea) a_head++;
          else b_head++;
          last_g     = eb;
          model_busy = 1'b1;
          cur_op     = op;
        end
        if (bus.a_resp_valid_o || bus.b_resp_valid_o) begin
          if (exp_q.size() == 0) begin
            check("spurious_resp", 128'({bus.a_resp_valid_o, bus.b_resp_valid_o}), 128'(0));
          end else begin
            e = exp_q[0];
            check("resp",
                  128'({bus.a_resp_valid_o, bus.b_resp_valid_o, bus.resp_data_o, bus.resp_zero_o, bus.resp_err_o}),
                  128'({!e.owner, e.owner, e.data, e.zero, e.err}));
            if (!seen) begin
              check("resp_latency", 128'(cyc), 128'(e.due));
              seen = 1'b1;
            end
            if (e.owner ? bus.b_resp_ready_i : bus.a_resp_ready_i) begin
              void'(exp_q.pop_front());
              seen       = 1'b0;
              model_busy = 1'b0;
            end
          end
        end else if (exp_q.size() > 0 && !seen && cyc > exp_q[0].due) begin
          check("resp_missing", 128'(0), 128'(1));
          seen = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t o;
    int  r, n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    push_a(3'b010, 5, 7);
    wait_idle(50);

    push_a(3'b110, 9, 9); push_a(3'b010, 1, 1);
    push_b(3'b001, 1, 2); push_b(3'b000, 3, 6);
    wait_idle(100);

    push_b(3'b011, 6, 7);
    wait_idle(50);

    push_a(3'b101, 11, 22);
    wait_idle(50);

    rr_mode = 2;
    push_a(3'b010, 100, 200);
    wait_busy(20);
    push_b(3'b110, 50, 8);
    repeat (6) @(posedge clk);
    #1 rr_mode = 0;
    wait_idle(50);

    push_a(3'b011, 123, 456);
    wait_busy(20);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_a(3'b010, 1, 2);
    push_b(3'b010, 3, 4);
    wait_idle(100);

    rr_mode = 1;
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 2);
      if (r != 1) begin o = rand_op(); push_a(o.ctrl, o.d1, o.d2); end
      if (r != 0) begin o = rand_op(); push_b(o.ctrl, o.d1, o.d2); end
      n = $urandom_range(1, 6);
      repeat (n) @(posedge clk);
      #1;
    end
    wait_idle(4000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
